cu_selection_sort: RTL and testbench

CU_SELECTION_SORT -- requirements
Module: cu_selection_sort

---
 rtl/cu_selection_sort.sv | 136 +++++++++++++
 tb/tb_cu_selection_sort.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cu_selection_sort.sv
// rtl/cu_selection_sort.sv - selection-sort control unit with dwell-gated status sampling and watchdog
//
// Sequences an external selection-sort datapath through LOAD, ANCHOR, FINDMIN and SHOW.
// Parameters:
//   N        number of elements handled by the datapath
//   TIMEOUT  maximum cycles allowed in any working state (2..65535)
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   run        start request, sampled in IDLE only
//   abort      cancel current sort (LOAD..DONE)
//   end_load   datapath: load finished
//   hit_i      datapath: outer index reached the end
//   hit_j      datapath: inner scan finished
//   end_show   datapath: show phase finished
//   j          datapath inner index
//   PS         state code: 0 IDLE, 1 LOAD, 2 ANCHOR, 3 FINDMIN, 4 SHOW, 5 DONE, 6 ERROR
//   swap       swap enable, FINDMIN with j at the last element
//   busy       PS in LOAD..SHOW
//   done       one-cycle completion pulse (PS == DONE)
//   err        watchdog error (PS == ERROR)
//   pass_cnt   completed FINDMIN passes, saturating at 15
//   cycle_cnt  working cycles of the current or last run, saturating

module cu_selection_sort #(
  parameter int N       = 5,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        abort,
  input  logic        end_load,
  input  logic        hit_i,
  input  logic        hit_j,
  input  logic        end_show,
  input  logic [3:0]  j,
  output logic [2:0]  PS,
  output logic        swap,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  pass_cnt,
  output logic [15:0] cycle_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_ANCHOR  = 3'd2;
  localparam logic [2:0] S_FINDMIN = 3'd3;
  localparam logic [2:0] S_SHOW    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  localparam logic [15:0] DWELL_LIM = 16'(TIMEOUT - 1);
  localparam logic [3:0]  J_LAST    = 4'(N - 1);

  logic [2:0]  ps_q;
  logic [2:0]  ps_d;
  logic [15:0] dwell;
  logic        pass_inc;
  logic        active;
  logic        flags_ok;
  logic        watchdog;

  assign active   = (ps_q >= S_LOAD) && (ps_q <= S_SHOW);
  // Datapath flags are registered one cycle behind PS, so on the first
  // cycle of a state they still describe the previous state.
  assign flags_ok = (dwell != 16'd0);
  assign watchdog = (dwell == DWELL_LIM);

  always_comb begin
    ps_d     = ps_q;
    pass_inc = 1'b0;
    case (ps_q)
      S_IDLE:    if (run) ps_d = S_LOAD;
      S_LOAD: begin
        if (end_load && flags_ok) ps_d = S_ANCHOR;
        else if (watchdog)        ps_d = S_ERROR;
      end
      S_ANCHOR: begin
        // hit_i becomes valid only one cycle after entry.
        if (dwell == 16'd1) ps_d = hit_i ? S_SHOW : S_FINDMIN;
        else if (watchdog)  ps_d = S_ERROR;
      end
      S_FINDMIN: begin
        if (hit_j && flags_ok) begin
          ps_d     = S_ANCHOR;
          pass_inc = 1'b1;
        end else if (watchdog) begin
          ps_d = S_ERROR;
        end
      end
      S_SHOW: begin
        if (end_show && flags_ok) ps_d = S_DONE;
        else if (watchdog)        ps_d = S_ERROR;
      end
      S_DONE:    ps_d = S_IDLE;
      S_ERROR:   if (!run) ps_d = S_IDLE;
      default:   ps_d = S_IDLE;
    endcase
    // Abort outranks every other exit, including the pass count.
    if (abort && (ps_q >= S_LOAD) && (ps_q <= S_DONE)) begin
      ps_d     = S_IDLE;
      pass_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q      <= S_IDLE;
      dwell     <= 16'd0;
      pass_cnt  <= 4'd0;
      cycle_cnt <= 16'd0;
    end else begin
      ps_q <= ps_d;
      if (ps_d != ps_q)          dwell <= 16'd0;
      else if (dwell != 16'hFFFF) dwell <= dwell + 16'd1;

      if ((ps_q == S_IDLE) && (ps_d == S_LOAD)) begin
        pass_cnt  <= 4'd0;
        cycle_cnt <= 16'd0;
      end else begin
        if (pass_inc && (pass_cnt != 4'hF))       pass_cnt  <= pass_cnt + 4'd1;
        if (active && (cycle_cnt != 16'hFFFF))    cycle_cnt <= cycle_cnt + 16'd1;
      end
    end
  end

  assign PS   = ps_q;
  assign busy = active;
  assign done = (ps_q == S_DONE);
  assign err  = (ps_q == S_ERROR);
  assign swap = (ps_q == S_FINDMIN) && (j >= J_LAST);

endmodule

// File: tb/tb_cu_selection_sort.sv
// tb/tb_cu_selection_sort.sv - directed self-checking bench for cu_selection_sort

module tb_cu_selection_sort;

  logic        clk;
  logic        rst;
  logic        run;
  logic        abort;
  logic        end_load;
  logic        hit_i;
  logic        hit_j;
  logic        end_show;
  logic [3:0]  j;
  logic [2:0]  PS;
  logic        swap;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  pass_cnt;
  logic [15:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  cu_selection_sort #(.N(5), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort),
    .end_load(end_load), .hit_i(hit_i), .hit_j(hit_j), .end_show(end_show),
    .j(j), .PS(PS), .swap(swap), .busy(busy), .done(done), .err(err),
    .pass_cnt(pass_cnt), .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; abort = 1'b0; end_load = 1'b0;
    hit_i = 1'b0; hit_j = 1'b0; end_show = 1'b0; j = 4'd0;

    tick(2);
    check("rst_ps", 32'(PS), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_swap", 32'(swap), 32'd0);
    check("rst_pass", 32'(pass_cnt), 32'd0);
    check("rst_cycle", 32'(cycle_cnt), 32'd0);
    rst = 1'b1;
    tick(1);
    check("idle_hold", 32'(PS), 32'd0);

    // Nominal sort
    run = 1'b1; tick(1); run = 1'b0;
    check("nom_load", 32'(PS), 32'd1);
    check("nom_busy", 32'(busy), 32'd1);
    tick(6); end_load = 1'b1; tick(1); end_load = 1'b0;
    check("nom_anchor", 32'(PS), 32'd2);
    check("nom_cycle_load", 32'(cycle_cnt), 32'd7);
    j = 4'd4; #1;
    check("swap_anchor_j4", 32'(swap), 32'd0);
    for (int p = 0; p < 3; p++) begin
      tick(2);
      check("nom_findmin", 32'(PS), 32'd3);
      if (p == 0) begin
        j = 4'd3; #1;
        check("swap_j3", 32'(swap), 32'd0);
        j = 4'd4; #1;
        check("swap_j4", 32'(swap), 32'd1);
      end
      tick(5); hit_j = 1'b1; tick(1); hit_j = 1'b0;
      check("nom_back_anchor", 32'(PS), 32'd2);
      check("nom_pass", 32'(pass_cnt), 32'(p + 1));
    end
    hit_i = 1'b1; tick(2); hit_i = 1'b0;
    check("nom_show", 32'(PS), 32'd4);
    tick(6); end_show = 1'b1; tick(1); end_show = 1'b0;
    check("nom_done_ps", 32'(PS), 32'd5);
    check("nom_done", 32'(done), 32'd1);
    check("nom_done_busy", 32'(busy), 32'd0);
    check("nom_pass3", 32'(pass_cnt), 32'd3);
    check("nom_cycle", 32'(cycle_cnt), 32'd40);
    tick(1);
    check("nom_idle", 32'(PS), 32'd0);
    check("nom_done_low", 32'(done), 32'd0);
    check("nom_cycle_hold", 32'(cycle_cnt), 32'd40);

    // Stale flags on state entry
    run = 1'b1; tick(1); run = 1'b0; end_load = 1'b1;
    check("stale_load_entry", 32'(PS), 32'd1);
    tick(1);
    check("stale_load_hold", 32'(PS), 32'd1);
    tick(1); end_load = 1'b0;
    check("stale_anchor", 32'(PS), 32'd2);
    tick(1); hit_j = 1'b1; tick(1);
    check("stale_find_entry", 32'(PS), 32'd3);
    tick(1);
    check("stale_find_hold", 32'(PS), 32'd3);
    tick(1); hit_j = 1'b0;
    check("stale_find_exit", 32'(PS), 32'd2);
    check("stale_pass", 32'(pass_cnt), 32'd1);

    // Abort racing hit_j in FINDMIN
    tick(2);
    check("abort_findmin", 32'(PS), 32'd3);
    tick(1); hit_j = 1'b1; abort = 1'b1; tick(1); hit_j = 1'b0; abort = 1'b0;
    check("abort_idle", 32'(PS), 32'd0);
    check("abort_pass", 32'(pass_cnt), 32'd1);
    check("abort_no_done", 32'(done), 32'd0);

    // Abort ignored in IDLE, then watchdog in LOAD
    run = 1'b1; abort = 1'b1; tick(1); abort = 1'b0;
    check("abort_in_idle", 32'(PS), 32'd1);
    tick(7);
    check("wd_load_hold", 32'(PS), 32'd1);
    tick(1);
    check("wd_error", 32'(PS), 32'd6);
    check("wd_err", 32'(err), 32'd1);
    check("wd_busy", 32'(busy), 32'd0);
    check("wd_cycle", 32'(cycle_cnt), 32'd8);
    tick(1);
    check("wd_error_hold", 32'(PS), 32'd6);
    run = 1'b0; tick(1);
    check("wd_idle", 32'(PS), 32'd0);
    check("wd_err_clr", 32'(err), 32'd0);

    // Reset mid-SHOW
    run = 1'b1; tick(1); run = 1'b0;
    tick(1); end_load = 1'b1; tick(1); end_load = 1'b0;
    hit_i = 1'b1; tick(2); hit_i = 1'b0;
    check("rs_show", 32'(PS), 32'd4);
    tick(2);
    #2 rst = 1'b0;
    #1;
    check("rs_ps", 32'(PS), 32'd0);
    check("rs_cycle", 32'(cycle_cnt), 32'd0);
    check("rs_pass", 32'(pass_cnt), 32'd0);
    check("rs_done", 32'(done), 32'd0);
    tick(1);
    rst = 1'b1;
    tick(1);
    check("rs_idle_after", 32'(PS), 32'd0);
    run = 1'b1; tick(1); run = 1'b0;
    check("rs_run_load", 32'(PS), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
